// File: rtl/gf2m58_reduce_seq.sv
// Sequential reduction of a 115-bit carry-less product modulo x^M + x^K + 1.
// Folds STEP high-order coefficients per clock from the top down; after a fixed
// ITER cycles the upper half is empty and the low M bits hold the remainder.
// Valid/ready on both sides, one product in flight at a time.
module gf2m58_reduce_seq #(
  parameter int M    = 58,
  parameter int K    = 19,
  parameter int STEP = 8,
  parameter int PW   = 2*M-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_rem,
  output logic          busy
);

  // Number of fold cycles; the counter only ever needs to reach ITER-1.
  localparam int ITER = (PW - M + STEP - 1) / STEP;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t         state_reg, state_next;
  logic [PW-1:0]  work_reg, work_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [M-1:0]   rem_reg, rem_next;

  int             p_val;
  int             lo_val;
  logic [PW-1:0]  win_mask;
  logic [PW-1:0]  fold;
  logic [PW-1:0]  work_fold;

  // Current fold window [lo_val, p_val]; never reaches below bit M.
  always_comb begin
    p_val  = (PW - 1) - STEP * int'(cnt_reg);
    lo_val = (p_val - STEP + 1 > M) ? (p_val - STEP + 1) : M;
  end

  // One mask bit per coefficient: set when that coefficient lies in the window.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_win
      if (gi < M) begin : g_low
        assign win_mask[gi] = 1'b0;
      end else begin : g_high
        assign win_mask[gi] = (gi <= p_val) && (gi >= lo_val);
      end
    end
  endgenerate

  // x^i = x^(i-M) * (x^K + 1): every set window bit is cleared and reappears at
  // i-M and i-M+K. With STEP <= M-K both targets sit strictly below the window,
  // so the whole window can be folded in parallel from the current contents.
  assign fold      = work_reg & win_mask;
  assign work_fold = work_reg ^ fold ^ (fold >> M) ^ (fold >> (M - K));

  // Next-state and datapath updates; outputs are decoded from state below.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next  = in_prod;
          cnt_next   = '0;
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        work_next = work_fold;
        cnt_next  = cnt_reg + CW'(1);
        if (cnt_reg == CW'(ITER - 1)) begin
          rem_next   = work_fold[M-1:0];
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_rem   = rem_reg;

endmodule

// File: tb/tb_gf2m58_reduce_seq.sv
// Directed and randomized checks of gf2m58_reduce_seq at STEP=8, 1 and 39.
module tb_gf2m58_reduce_seq;

  localparam int M  = 58;
  localparam int PW = 115;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_prod;
  logic          out_ready;
  logic          in_ready;
  logic          out_valid;
  logic [M-1:0]  out_rem;
  logic          busy;

  // Shared stimulus for the STEP=1 and STEP=39 instances.
  logic          in_valid2;
  logic [PW-1:0] in_prod2;
  logic          in_ready1, out_valid1, busy1;
  logic [M-1:0]  out_rem1;
  logic          in_ready39, out_valid39, busy39;
  logic [M-1:0]  out_rem39;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf2m58_reduce_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready),
    .out_rem(out_rem), .busy(busy)
  );

  gf2m58_reduce_seq #(.STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready1),
    .in_prod(in_prod2), .out_valid(out_valid1), .out_ready(1'b1),
    .out_rem(out_rem1), .busy(busy1)
  );

  gf2m58_reduce_seq #(.STEP(39)) dut39 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready39),
    .in_prod(in_prod2), .out_valid(out_valid39), .out_ready(1'b1),
    .out_rem(out_rem39), .busy(busy39)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bitwise long division by x^58 + x^19 + 1, top coefficient first.
  function automatic logic [M-1:0] ref_mod(input logic [PW-1:0] a);
    logic [PW-1:0] r;
    r = a;
    for (int i = PW - 1; i >= M; i--) begin
      if (r[i]) begin
        r[i]          = 1'b0;
        r[i - M]      = ~r[i - M];
        r[i - M + 19] = ~r[i - M + 19];
      end
    end
    return r[M-1:0];
  endfunction

  function automatic logic [PW-1:0] xpow(input int e);
    logic [PW-1:0] v;
    v = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  // One full transaction on the STEP=8 instance with out_ready held high.
  task automatic xact8(input string tag, input logic [PW-1:0] p, input logic [M-1:0] exp);
    int lat;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_prod   = p;
    tick;
    in_valid  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_rem"}, out_rem, exp);
    $display("xact %s prod=%h rem=%h lat=%0d", tag, p, out_rem, lat);
    tick;
    chk({tag, "_idle"}, {busy, in_ready, out_valid}, 3'b010);
  endtask

  // One transaction into both alternate-STEP instances, checking each latency.
  task automatic xact_alt(input string tag, input logic [PW-1:0] p);
    int n, lat1, lat39;
    logic [M-1:0] r1, r39;
    lat1 = -1; lat39 = -1; r1 = '0; r39 = '0;
    in_valid2 = 1'b1;
    in_prod2  = p;
    tick;
    in_valid2 = 1'b0;
    n = 0;
    while ((lat1 < 0 || lat39 < 0) && n < 100) begin
      if (out_valid1 && lat1 < 0) begin lat1 = n; r1 = out_rem1; end
      if (out_valid39 && lat39 < 0) begin lat39 = n; r39 = out_rem39; end
      if (lat1 < 0 || lat39 < 0) begin
        tick;
        n++;
      end
    end
    chk({tag, "_lat_s1"}, lat1, 57);
    chk({tag, "_lat_s39"}, lat39, 2);
    chk({tag, "_rem_s1"}, r1, ref_mod(p));
    chk({tag, "_rem_s39"}, r39, ref_mod(p));
    $display("xact %s prod=%h rem1=%h lat1=%0d rem39=%h lat39=%0d", tag, p, r1, lat1, r39, lat39);
    tick;
    chk({tag, "_alt_idle"}, {in_ready1, in_ready39}, 2'b11);
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [M-1:0]  e;
    int lat;

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_prod2 = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset_flags", {busy, in_ready, out_valid}, 3'b010);
    chk("reset_rem", out_rem, 58'h0);

    // Directed vectors with hand-derived remainders.
    xact8("x114", xpow(114), 58'h0100_0010_0002_0000);
    xact8("x58", xpow(58), 58'h0000_0000_0008_0001);
    xact8("ones58", 115'h3FF_FFFF_FFFF_FFFF, 58'h3FF_FFFF_FFFF_FFFF);
    xact8("x70", xpow(70), 58'h0000_0000_8000_1000);
    xact8("x96", xpow(96), 58'h200_0040_0000_0000);
    xact8("x97", xpow(97), 58'h0000_0080_0008_0001);
    xact8("zero", '0, 58'h0);
    xact8("mix", xpow(114) | xpow(58) | xpow(0), 58'h0100_0010_000A_0000);

    // Back-pressure: result held, inputs refused, stray in_valid ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_prod   = xpow(114);
    tick;
    in_valid  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick; lat++; end
    chk("bp_lat", lat, 8);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2);
      in_prod  = xpow(70);
      chk("bp_hold_valid", {out_valid, in_ready, busy}, 3'b101);
      chk("bp_hold_rem", out_rem, 58'h0100_0010_0002_0000);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_release", {busy, in_ready, out_valid}, 3'b010);
    tick; tick;
    chk("bp_no_capture", {busy, out_valid}, 2'b00);
    chk("bp_rem_kept", out_rem, 58'h0100_0010_0002_0000);

    // Reset during the 4th REDUCE cycle discards the product.
    in_valid = 1'b1;
    in_prod  = xpow(114);
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    chk("rst_mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick;
    chk("rst_mid_flags", {busy, in_ready, out_valid}, 3'b010);
    chk("rst_mid_rem", out_rem, 58'h0);
    // Reset and in_valid on the same edge: nothing captured.
    in_valid = 1'b1;
    in_prod  = xpow(114);
    tick;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid", {busy, in_ready}, 2'b01);
    xact8("post_rst_x58", xpow(58), 58'h0000_0000_0008_0001);

    // Randomized products with gaps, back-pressure and stray in_valid.
    for (int n = 0; n < 200; n++) begin
      p = PW'({$urandom, $urandom, $urandom, $urandom});
      if (n % 10 == 0) p[PW-1:M] = '0;
      e = ref_mod(p);
      repeat ($urandom_range(0, 3)) tick;
      out_ready = $urandom_range(0, 1) == 1;
      in_valid  = 1'b1;
      in_prod   = p;
      tick;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin tick; lat++; end
      chk("rnd_lat", lat, 8);
      chk("rnd_rem", out_rem, e);
      repeat ($urandom_range(0, 3)) begin
        in_valid = $urandom_range(0, 1) == 1;
        in_prod  = PW'({$urandom, $urandom, $urandom, $urandom});
        tick;
        chk("rnd_hold", out_rem, e);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      $display("xact rnd%0d prod=%h rem=%h lat=%0d", n, p, out_rem, lat);
      tick;
      out_ready = 1'b0;
      chk("rnd_idle", {busy, in_ready}, 2'b01);
    end

    // Alternate STEP settings: latency 57 for STEP=1, 2 for STEP=39.
    xact_alt("alt_x114", xpow(114));
    xact_alt("alt_x58", xpow(58));
    for (int n = 0; n < 20; n++) begin
      xact_alt("alt_rnd", PW'({$urandom, $urandom, $urandom, $urandom}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
